// File: rtl/pref_pkg.sv
// Shared address types for the stride prefetcher and its issue queue.
// Cache-line addresses (cla) drop the byte offset inside a 64-byte block.
package pref_pkg;
  localparam int ADDR_SIZE       = 64;
  localparam int LOG2_BLOCK_SIZE = 6;
  localparam int CLA_SIZE        = ADDR_SIZE - LOG2_BLOCK_SIZE;

  typedef logic [ADDR_SIZE-1:0] addr_t;
  typedef logic [CLA_SIZE-1:0]  cla_t;

  function automatic cla_t to_cla(input addr_t a);
    return a[ADDR_SIZE-1:LOG2_BLOCK_SIZE];
  endfunction

  function automatic addr_t to_addr(input cla_t c);
    return {c, {LOG2_BLOCK_SIZE{1'b0}}};
  endfunction
endpackage

// File: rtl/pref_issue_queue_if.sv
// Request port from the prefetch issue queue to the cache/memory side.
// The issue queue drives the master modport.
interface pref_issue_queue_if;
  import pref_pkg::*;

  addr_t req_addr;
  logic  req_valid;
  logic  req_ready;

  modport master (output req_addr, output req_valid, input req_ready);
  modport slave  (input req_addr, input req_valid, output req_ready);
endinterface

// File: rtl/pref_recent_filter.sv
// CAM of recently issued cache lines with round-robin replacement.
// Lookups see the contents before this cycle's insert.
module pref_recent_filter
  import pref_pkg::*;
#(
  parameter int RECENT = 16
) (
  input  logic           clk,
  input  logic           rst,
  input  cla_t [2:0]     look_cla_i,
  input  logic           ins_en_i,
  input  cla_t           ins_cla_i,
  input  logic           flush_i,
  output logic [2:0]     hit_o
);
  localparam int PTR_W = $clog2(RECENT);

  cla_t              ent_q [RECENT];
  logic [RECENT-1:0] vld_q, vld_d;
  logic [PTR_W-1:0]  ptr_q, ptr_d;

  always_comb begin
    hit_o = '0;
    for (int k = 0; k < 3; k++) begin
      for (int i = 0; i < RECENT; i++) begin
        if (vld_q[i] && (ent_q[i] == look_cla_i[k])) hit_o[k] = 1'b1;
      end
    end
  end

  always_comb begin
    vld_d = vld_q;
    ptr_d = ptr_q;
    if (flush_i) begin
      vld_d = '0;
      ptr_d = '0;
    end else if (ins_en_i) begin
      vld_d[ptr_q] = 1'b1;
      ptr_d        = ptr_q + PTR_W'(1);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      vld_q <= '0;
      ptr_q <= '0;
    end else begin
      vld_q <= vld_d;
      ptr_q <= ptr_d;
    end
  end

  // Entry payload is qualified by vld_q, so it needs no reset.
  always_ff @(posedge clk) begin
    if (!flush_i && ins_en_i) ent_q[ptr_q] <= ins_cla_i;
  end
endmodule

// File: rtl/pref_issue_queue.sv
// Prefetch issue queue: dedups up to three candidates per cycle against the FIFO and
// the recent-issue filter, buffers survivors in order and issues one per cycle.
module pref_issue_queue
  import pref_pkg::*;
#(
  parameter int DEPTH  = 8,
  parameter int RECENT = 16,
  parameter int CNT_W  = 16
) (
  input  logic                     clk,
  input  logic                     rst,
  input  addr_t                    pref_addr1_i,
  input  logic                     pref_valid1_i,
  input  addr_t                    pref_addr2_i,
  input  logic                     pref_valid2_i,
  input  addr_t                    pref_addr3_i,
  input  logic                     pref_valid3_i,
  input  logic                     flush_i,
  pref_issue_queue_if.master       req,
  output logic [$clog2(DEPTH):0]   count_o,
  output logic [CNT_W-1:0]         drop_cnt_o,
  output logic [CNT_W-1:0]         issue_cnt_o
);
  localparam int PTR_W = $clog2(DEPTH);
  localparam int OCC_W = PTR_W + 1;

  cla_t              mem_q [DEPTH];
  logic [PTR_W-1:0]  head_q, head_d, tail_q, tail_d;
  logic [OCC_W-1:0]  count_q, count_d, free_slots;
  logic [CNT_W-1:0]  drop_q, drop_d, issue_q, issue_d;

  cla_t [2:0]        cand_cla;
  logic [2:0]        cand_vld, filt_hit, acc;
  logic [PTR_W-1:0]  wr_idx [3];
  logic [1:0]        n_acc, n_drop;
  logic [DEPTH-1:0]  occ;
  logic              issue;
  logic              unused_lsbs;

  function automatic logic [CNT_W-1:0] sat_add(input logic [CNT_W-1:0] cnt,
                                               input logic [1:0] inc);
    logic [CNT_W:0] sum;
    sum = {1'b0, cnt} + {{(CNT_W-1){1'b0}}, inc};
    return sum[CNT_W] ? {CNT_W{1'b1}} : sum[CNT_W-1:0];
  endfunction

  assign cand_cla[0]  = to_cla(pref_addr1_i);
  assign cand_cla[1]  = to_cla(pref_addr2_i);
  assign cand_cla[2]  = to_cla(pref_addr3_i);
  assign cand_vld     = {pref_valid3_i, pref_valid2_i, pref_valid1_i};
  assign unused_lsbs  = ^{pref_addr1_i[LOG2_BLOCK_SIZE-1:0], pref_addr2_i[LOG2_BLOCK_SIZE-1:0],
                          pref_addr3_i[LOG2_BLOCK_SIZE-1:0]};

  assign req.req_valid = (count_q != '0);
  assign req.req_addr  = req.req_valid ? to_addr(mem_q[head_q]) : '0;
  assign issue         = req.req_valid & req.req_ready & ~flush_i;
  assign free_slots    = OCC_W'(DEPTH) - count_q;

  pref_recent_filter #(.RECENT(RECENT)) u_filter (
    .clk        (clk),
    .rst        (rst),
    .look_cla_i (cand_cla),
    .ins_en_i   (issue),
    .ins_cla_i  (mem_q[head_q]),
    .flush_i    (flush_i),
    .hit_o      (filt_hit)
  );

  // Slot i is live when its distance from head is below the occupancy.
  always_comb begin
    occ = '0;
    for (int i = 0; i < DEPTH; i++) begin
      occ[i] = ({1'b0, PTR_W'(i) - head_q} < count_q);
    end
  end

  // In-order dedup and drop-newest admission; a head issuing this cycle still blocks.
  always_comb begin
    logic dup;
    acc    = '0;
    n_acc  = '0;
    n_drop = '0;
    for (int k = 0; k < 3; k++) begin
      dup       = filt_hit[k];
      wr_idx[k] = tail_q + PTR_W'(n_acc);
      for (int i = 0; i < DEPTH; i++) begin
        if (occ[i] && (mem_q[i] == cand_cla[k])) dup = 1'b1;
      end
      for (int j = 0; j < k; j++) begin
        if (acc[j] && (cand_cla[j] == cand_cla[k])) dup = 1'b1;
      end
      if (cand_vld[k]) begin
        if (!dup && (OCC_W'(n_acc) < free_slots)) begin
          acc[k] = 1'b1;
          n_acc  = n_acc + 2'd1;
        end else begin
          n_drop = n_drop + 2'd1;
        end
      end
    end
    if (flush_i) begin
      acc    = '0;
      n_acc  = '0;
      n_drop = '0;
    end
  end

  always_comb begin
    head_d  = head_q + PTR_W'(issue);
    tail_d  = tail_q + PTR_W'(n_acc);
    count_d = count_q + OCC_W'(n_acc) - OCC_W'(issue);
    if (flush_i) begin
      head_d  = '0;
      tail_d  = '0;
      count_d = '0;
    end
    drop_d  = sat_add(drop_q, n_drop);
    issue_d = sat_add(issue_q, {1'b0, issue});
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
      drop_q  <= '0;
      issue_q <= '0;
    end else begin
      head_q  <= head_d;
      tail_q  <= tail_d;
      count_q <= count_d;
      drop_q  <= drop_d;
      issue_q <= issue_d;
    end
  end

  always_ff @(posedge clk) begin
    for (int k = 0; k < 3; k++) begin
      if (acc[k]) mem_q[wr_idx[k]] <= cand_cla[k];
    end
  end

  assign count_o     = count_q;
  assign drop_cnt_o  = drop_q;
  assign issue_cnt_o = issue_q;
endmodule
